// File: rtl/tanh_lane_block_pkg.sv
// Shared training-datapath constants for the tanh activation stage.
// Element formats are signed fixed point with FRAC fractional bits.
package tanh_lane_block_pkg;
  localparam int DIM     = 24;
  localparam int D_W     = 16;
  localparam int Q_W     = 16;
  localparam int FRAC    = 12;
  localparam int TBL_LAT = 2;
  localparam int ONE     = 1 << FRAC;
endpackage

// File: rtl/tanh_lane_block_if.sv
// Vector-level handshake between matmul output, activation stage and next layer.
// run is a level; valid qualifies the whole q vector; no backpressure.
interface tanh_lane_block_if;
  import tanh_lane_block_pkg::*;

  logic                 run;
  logic                 mode;
  logic [DIM*D_W-1:0]   d;
  logic                 valid;
  logic [DIM*Q_W-1:0]   q;

  modport master (output run, mode, d, input valid, q);
  modport slave  (input run, mode, d, output valid, q);
endinterface

// File: rtl/tanh_lane_block_lut.sv
// tanh lookup: 33-knot table over |x| in [0,4) with linear interpolation, odd symmetry.
// Latency TBL_LAT cycles (registered output); always accepts a new input, no backpressure.
module tanh_lut #(
  parameter int D_W     = 16,
  parameter int Q_W     = 16,
  parameter int FRAC    = 12,
  parameter int TBL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [D_W-1:0] x,
  output logic signed [Q_W-1:0] y
);
  localparam int STEP_B = FRAC - 3;
  localparam int ONE_L  = 1 << FRAC;
  localparam logic [D_W:0] SAT_TH = (D_W+1)'(4 << FRAC);

  if (FRAC != 12 || TBL_LAT < 1 || TBL_LAT > 4) begin : g_chk
    $error("tanh_lut: table is built for FRAC=12 and TBL_LAT in 1..4");
  end

  // Knots are round(tanh(i/8) * 4096).
  function automatic logic [12:0] knot(input logic [5:0] i);
    case (i)
      6'd0:  return 13'd0;    6'd1:  return 13'd509;  6'd2:  return 13'd1003;
      6'd3:  return 13'd1468; 6'd4:  return 13'd1893; 6'd5:  return 13'd2272;
      6'd6:  return 13'd2602; 6'd7:  return 13'd2883; 6'd8:  return 13'd3119;
      6'd9:  return 13'd3315; 6'd10: return 13'd3475; 6'd11: return 13'd3604;
      6'd12: return 13'd3707; 6'd13: return 13'd3790; 6'd14: return 13'd3856;
      6'd15: return 13'd3908; 6'd16: return 13'd3949; 6'd17: return 13'd3981;
      6'd18: return 13'd4006; 6'd19: return 13'd4026; 6'd20: return 13'd4041;
      6'd21: return 13'd4053; 6'd22: return 13'd4063; 6'd23: return 13'd4070;
      6'd24: return 13'd4076; 6'd25: return 13'd4080; 6'd26: return 13'd4084;
      6'd27: return 13'd4086; 6'd28: return 13'd4089; 6'd29: return 13'd4090;
      6'd30: return 13'd4091; 6'd31: return 13'd4092; 6'd32: return 13'd4093;
      default: return 13'd4096;
    endcase
  endfunction

  logic [D_W:0]          xe, ax;
  logic                  neg, sat;
  logic [4:0]            idx;
  logic [STEP_B-1:0]     fr;
  logic [12:0]           k0, k1, mag;
  logic [12+STEP_B:0]    prod;
  logic signed [Q_W-1:0] m_s, y_c;

  always_comb begin
    xe   = {x[D_W-1], x};
    neg  = x[D_W-1];
    ax   = neg ? (~xe + (D_W+1)'(1)) : xe;
    sat  = (ax >= SAT_TH);
    idx  = ax[STEP_B+4:STEP_B];
    fr   = ax[STEP_B-1:0];
    k0   = knot({1'b0, idx});
    k1   = knot({1'b0, idx} + 6'd1);
    prod = (13+STEP_B)'(k1 - k0) * (13+STEP_B)'(fr);
    mag  = sat ? 13'(ONE_L) : k0 + 13'(prod >> STEP_B);
    m_s  = Q_W'(mag);
    y_c  = neg ? -m_s : m_s;
  end

  logic signed [Q_W-1:0] pipe [TBL_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TBL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= y_c;
      for (int i = 1; i < TBL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[TBL_LAT-1];
endmodule

// File: rtl/tanh_lane_block.sv
// Elementwise tanh / (1 - tanh^2) over DIM elements, LANES per beat; latency BEATS+TBL_LAT+mode.
// No backpressure: run is a level, dropping it flushes in-flight beats and clears valid.
module tanh_lane_block
  import tanh_lane_block_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  tanh_lane_block_if.slave  bus
);
  localparam int BEATS = DIM / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (DIM % LANES != 0) begin : g_chk
    $error("tanh_lane_block: DIM must be a multiple of LANES");
  end

  function automatic logic signed [Q_W-1:0] deriv(input logic signed [Q_W-1:0] y);
    logic signed [2*Q_W-1:0] ye, sq, diff;
    ye   = (2*Q_W)'(y);
    sq   = (ye * ye) >>> FRAC;
    diff = (2*Q_W)'(ONE) - sq;
    if (diff < 0) diff = '0;
    return Q_W'(diff);
  endfunction

  logic [CNT_W-1:0]      cnt;
  logic                  last_issued, started, mode_q, done;
  logic                  tag_p  [TBL_LAT];
  logic [CNT_W-1:0]      beat_p [TBL_LAT];
  logic                  dv_tag;
  logic [CNT_W-1:0]      dv_beat;
  logic signed [D_W-1:0] x_lane [LANES];
  logic signed [Q_W-1:0] y_lut  [LANES];
  logic signed [Q_W-1:0] dv_y   [LANES];
  logic signed [Q_W-1:0] wr_y   [LANES];
  logic                  wr_en;
  logic [CNT_W-1:0]      wr_beat;
  logic [DIM*Q_W-1:0]    q_r;

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      x_lane[j] = bus.d[(int'(cnt)*LANES + j)*D_W +: D_W];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    tanh_lut #(.D_W(D_W), .Q_W(Q_W), .FRAC(FRAC), .TBL_LAT(TBL_LAT)) u_lut (
      .clk (clk),
      .rst (rst),
      .x   (x_lane[j]),
      .y   (y_lut[j])
    );
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) dv_y[j] <= deriv(y_lut[j]);
  end

  // Writeback taps either the table output or the derivative register, per the latched mode.
  always_comb begin
    wr_en   = mode_q ? dv_tag  : tag_p[TBL_LAT-1];
    wr_beat = mode_q ? dv_beat : beat_p[TBL_LAT-1];
    for (int j = 0; j < LANES; j++) wr_y[j] = mode_q ? dv_y[j] : y_lut[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      last_issued <= 1'b0;
      started     <= 1'b0;
      mode_q      <= 1'b0;
      done        <= 1'b0;
      dv_tag      <= 1'b0;
      dv_beat     <= '0;
      q_r         <= '0;
      for (int i = 0; i < TBL_LAT; i++) begin
        tag_p[i]  <= 1'b0;
        beat_p[i] <= '0;
      end
    end else if (!bus.run) begin
      cnt         <= '0;
      last_issued <= 1'b0;
      started     <= 1'b0;
      done        <= 1'b0;
      dv_tag      <= 1'b0;
      for (int i = 0; i < TBL_LAT; i++) tag_p[i] <= 1'b0;
    end else begin
      started <= 1'b1;
      if (!started) mode_q <= bus.mode;
      if (cnt != LAST) cnt <= cnt + CNT_W'(1);
      if (cnt == LAST) last_issued <= 1'b1;
      tag_p[0]  <= ~last_issued;
      beat_p[0] <= cnt;
      for (int i = 1; i < TBL_LAT; i++) begin
        tag_p[i]  <= tag_p[i-1];
        beat_p[i] <= beat_p[i-1];
      end
      dv_tag  <= tag_p[TBL_LAT-1];
      dv_beat <= beat_p[TBL_LAT-1];
      if (wr_en) begin
        for (int j = 0; j < LANES; j++) begin
          q_r[(int'(wr_beat)*LANES + j)*Q_W +: Q_W] <= wr_y[j];
        end
        if (wr_beat == LAST) done <= 1'b1;
      end
    end
  end

  assign bus.q     = q_r;
  assign bus.valid = bus.run & done;
endmodule
